// File: rtl/sram_responder.sv
// Shared single-array SRAM responder: read-only instruction port plus a
// byte-writable data port, both answering one cycle after the request.

module sram_responder_lane #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [7:0]    w_byte,
    input  logic          i_upd,
    input  logic          i_hit,
    input  logic [AW-1:0] i_idx,
    input  logic          d_upd,
    input  logic          d_hit,
    input  logic [AW-1:0] d_idx,
    output logic [7:0]    i_byte,
    output logic [7:0]    d_byte
);
    logic [7:0] mem_q [2**AW];
    logic [7:0] i_byte_q, i_byte_d;
    logic [7:0] d_byte_q, d_byte_d;

    // Reset only suppresses the write; array contents survive reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
        end else if (we) begin
            mem_q[d_idx] <= w_byte;
        end
    end

    always_comb begin
        i_byte_d = i_byte_q;
        d_byte_d = d_byte_q;
        if (i_upd) i_byte_d = i_hit ? mem_q[i_idx] : 8'h00;
        if (d_upd) d_byte_d = d_hit ? mem_q[d_idx] : 8'h00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_byte_q <= 8'h00;
            d_byte_q <= 8'h00;
        end else begin
            i_byte_q <= i_byte_d;
            d_byte_q <= d_byte_d;
        end
    end

    assign i_byte = i_byte_q;
    assign d_byte = d_byte_q;
endmodule

module sram_responder #(
    parameter int          AW   = 12,
    parameter logic [31:0] BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        err_oor,
    output logic        err_iwr,
    output logic [31:0] err_addr,
    output logic [15:0] wr_count
);
    localparam int       NUM_LANES = 4;
    localparam logic [32:0] SPAN   = 33'd4 << AW;

    logic [31:0] i_off, d_off;
    logic        i_in, d_in;
    logic [AW-1:0] i_idx, d_idx;
    logic        i_oor, d_oor, d_rd, d_wr, commit;
    logic        unused_bits;

    // Offsets wrap modulo 2^32, so addresses below BASE land far out of range.
    assign i_off  = inst_sram_addr - BASE;
    assign d_off  = data_sram_addr - BASE;
    assign i_in   = {1'b0, i_off} < SPAN;
    assign d_in   = {1'b0, d_off} < SPAN;
    assign i_idx  = i_off[AW+1:2];
    assign d_idx  = d_off[AW+1:2];
    assign i_oor  = inst_sram_en && !i_in;
    assign d_oor  = data_sram_en && !d_in;
    assign d_rd   = data_sram_en && (data_sram_wen == 4'b0000);
    assign d_wr   = data_sram_en && (data_sram_wen != 4'b0000);
    assign commit = d_wr && d_in;

    assign unused_bits = ^{inst_sram_wdata, i_off, d_off};

    logic [NUM_LANES-1:0][7:0] i_rd, d_rd_data, w_bytes;
    assign w_bytes = data_sram_wdata;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        sram_responder_lane #(.AW(AW)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .we     (commit && data_sram_wen[g]),
            .w_byte (w_bytes[g]),
            .i_upd  (inst_sram_en),
            .i_hit  (i_in),
            .i_idx  (i_idx),
            .d_upd  (d_rd),
            .d_hit  (d_in),
            .d_idx  (d_idx),
            .i_byte (i_rd[g]),
            .d_byte (d_rd_data[g])
        );
    end

    assign inst_sram_rdata = i_rd;
    assign data_sram_rdata = d_rd_data;

    logic        err_oor_q, err_oor_d;
    logic        err_iwr_q, err_iwr_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [15:0] wr_count_q, wr_count_d;

    always_comb begin
        err_oor_d  = err_oor_q;
        err_iwr_d  = err_iwr_q;
        err_addr_d = err_addr_q;
        wr_count_d = wr_count_q;
        // Only the first offending address is kept; data port wins a tie.
        if (i_oor || d_oor) begin
            err_oor_d = 1'b1;
            if (!err_oor_q) err_addr_d = d_oor ? data_sram_addr : inst_sram_addr;
        end
        if (inst_sram_en && (inst_sram_wen != 4'b0000)) err_iwr_d = 1'b1;
        if (commit && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_oor_q  <= 1'b0;
            err_iwr_q  <= 1'b0;
            err_addr_q <= 32'h0;
            wr_count_q <= 16'h0;
        end else begin
            err_oor_q  <= err_oor_d;
            err_iwr_q  <= err_iwr_d;
            err_addr_q <= err_addr_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign err_oor  = err_oor_q;
    assign err_iwr  = err_iwr_q;
    assign err_addr = err_addr_q;
    assign wr_count = wr_count_q;
endmodule

// File: tb/tb_sram_responder.sv
// Directed plus randomized bench for sram_responder against a word-array
// reference model (BASE=0, AW=12).

module tb_sram_responder;
    localparam int unsigned WORDS = 4096;
    localparam int unsigned SPAN  = 4 * WORDS;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_sram_en = 1'b0;
    logic [3:0]  inst_sram_wen = 4'h0;
    logic [31:0] inst_sram_addr = 32'h0;
    logic [31:0] inst_sram_wdata = 32'h0;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en = 1'b0;
    logic [3:0]  data_sram_wen = 4'h0;
    logic [31:0] data_sram_addr = 32'h0;
    logic [31:0] data_sram_wdata = 32'h0;
    logic [31:0] data_sram_rdata;
    logic        err_oor, err_iwr;
    logic [31:0] err_addr;
    logic [15:0] wr_count;

    sram_responder #(.AW(12), .BASE(32'h0)) dut (
        .clk(clk), .rst(rst),
        .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .err_oor(err_oor), .err_iwr(err_iwr), .err_addr(err_addr), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] mem_m [WORDS];
    logic [31:0] ir_m, dr_m, ea_m;
    bit          eo_m, ei_m;
    int          wc_m;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_irdata"}, inst_sram_rdata, ir_m);
        chk({tag, "_drdata"}, data_sram_rdata, dr_m);
        chk({tag, "_err_oor"}, {31'b0, err_oor}, {31'b0, eo_m});
        chk({tag, "_err_iwr"}, {31'b0, err_iwr}, {31'b0, ei_m});
        chk({tag, "_err_addr"}, err_addr, ea_m);
        chk({tag, "_wr_count"}, {16'h0, wr_count}, 32'(wc_m));
    endtask

    task automatic model_reset();
        ir_m = 0; dr_m = 0; ea_m = 0; eo_m = 0; ei_m = 0; wc_m = 0;
    endtask

    // One clock of the spec's rules: reads see the array before this edge's write.
    task automatic model_step(input bit ie, input logic [3:0] iw, input logic [31:0] ia,
                              input bit de, input logic [3:0] dw, input logic [31:0] da,
                              input logic [31:0] dd);
        bit iin = (ia < SPAN);
        bit din = (da < SPAN);
        int ii = int'(ia / 4) % WORDS;
        int di = int'(da / 4) % WORDS;
        if (ie) ir_m = iin ? mem_m[ii] : 32'h0;
        if (de && dw == 0) dr_m = din ? mem_m[di] : 32'h0;
        if ((ie && !iin) || (de && !din)) begin
            if (!eo_m) ea_m = (de && !din) ? da : ia;
            eo_m = 1;
        end
        if (ie && iw != 0) ei_m = 1;
        if (de && dw != 0 && din) begin
            for (int b = 0; b < 4; b++)
                if (dw[b]) mem_m[di][8*b +: 8] = dd[8*b +: 8];
            if (wc_m < 65535) wc_m++;
        end
    endtask

    task automatic step(input bit ie, input logic [3:0] iw, input logic [31:0] ia,
                        input bit de, input logic [3:0] dw, input logic [31:0] da,
                        input logic [31:0] dd, input bit do_chk, input string tag);
        inst_sram_en = ie; inst_sram_wen = iw; inst_sram_addr = ia;
        inst_sram_wdata = $urandom;
        data_sram_en = de; data_sram_wen = dw; data_sram_addr = da; data_sram_wdata = dd;
        model_step(ie, iw, ia, de, dw, da, dd);
        @(posedge clk); #1;
        if (do_chk) check_all(tag);
    endtask

    task automatic idle(input bit do_chk, input string tag);
        step(0, 4'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, do_chk, tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 0;
        inst_sram_en = 0; data_sram_en = 0;
        @(posedge clk); #1;
        model_reset();
        check_all(tag);
        rst = 1;
    endtask

    function automatic logic [31:0] rnd_addr(input bit allow_oor);
        logic [31:0] a;
        if (allow_oor && $urandom_range(0, 5) == 0) begin
            a = $urandom;
            if (a < SPAN) a = a + SPAN;
        end else begin
            a = 32'($urandom_range(0, SPAN - 1));
        end
        return a;
    endfunction

    task automatic random_phase(input int n, input bit allow_oor, input string tag);
        logic [31:0] ia, da;
        logic [3:0]  iw, dw;
        for (int k = 0; k < n; k++) begin
            da = rnd_addr(allow_oor);
            ia = ($urandom_range(0, 3) == 0) ? da : rnd_addr(allow_oor);
            iw = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            dw = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
            step($urandom_range(0, 1) == 1, iw, ia, $urandom_range(0, 1) == 1, dw, da,
                 $urandom, 1, tag);
        end
    endtask

    initial begin
        logic [31:0] keep;
        // Reset then idle
        do_reset("reset");
        for (int k = 0; k < 5; k++) idle(1, "idle");

        // Write then read, low address bits ignored on the instruction port
        step(0, 4'h0, 32'h0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 1, "wr10");
        chk("wr10_count", {16'h0, wr_count}, 32'd1);
        step(1, 4'h0, 32'h12, 1, 4'h0, 32'h10, 32'h0, 1, "rd10");
        chk("rd10_data", data_sram_rdata, 32'hDEADBEEF);
        chk("rd12_inst", inst_sram_rdata, 32'hDEADBEEF);

        // Byte lanes
        step(0, 4'h0, 32'h0, 1, 4'hF, 32'h10, 32'h11223344, 1, "bl_full");
        step(0, 4'h0, 32'h0, 1, 4'b0101, 32'h10, 32'hAABBCCDD, 1, "bl_part");
        step(0, 4'h0, 32'h0, 1, 4'h0, 32'h10, 32'h0, 1, "bl_rd");
        chk("bl_merge", data_sram_rdata, 32'h11BB33DD);

        // Read-during-write returns the old word on the instruction port
        step(0, 4'h0, 32'h0, 1, 4'hF, 32'h20, 32'h1, 1, "rdw_init");
        step(1, 4'h0, 32'h20, 1, 4'hF, 32'h20, 32'h2, 1, "rdw_same");
        chk("rdw_old", inst_sram_rdata, 32'h1);
        step(1, 4'h0, 32'h20, 0, 4'h0, 32'h0, 32'h0, 1, "rdw_next");
        chk("rdw_new", inst_sram_rdata, 32'h2);
        chk("rdw_drd_hold", data_sram_rdata, 32'h11BB33DD);

        // Fill the array so every later read has a known value
        for (int w = 0; w < int'(WORDS); w++)
            step(0, 4'h0, 32'h0, 1, 4'hF, 32'(w * 4), $urandom, 0, "fill");
        idle(1, "fill_done");

        random_phase(400, 0, "rnd_in");

        // Out-of-range handling
        keep = {16'h0, wr_count};
        step(0, 4'h0, 32'h0, 1, 4'hF, 32'h0000_4000, 32'h55AA55AA, 1, "oor_wr");
        chk("oor_wr_count", {16'h0, wr_count}, keep);
        step(0, 4'h0, 32'h0, 1, 4'h0, 32'h0000_4000, 32'h0, 1, "oor_rd");
        chk("oor_rdata", data_sram_rdata, 32'h0);
        chk("oor_flag", {31'b0, err_oor}, 32'd1);
        chk("oor_addr", err_addr, 32'h0000_4000);
        step(1, 4'h0, 32'hFFFF_FFF0, 0, 4'h0, 32'h0, 32'h0, 1, "oor_second");
        chk("oor_addr_sticky", err_addr, 32'h0000_4000);
        chk("oor_inst_zero", inst_sram_rdata, 32'h0);

        random_phase(400, 1, "rnd_oor");

        // Reset during a write: nothing commits, outputs clear
        inst_sram_en = 1; inst_sram_addr = 32'h40;
        data_sram_en = 1; data_sram_wen = 4'hF; data_sram_addr = 32'h40;
        data_sram_wdata = ~mem_m[16];
        #2 rst = 0;
        @(posedge clk); #1;
        model_reset();
        check_all("midrst");
        rst = 1;
        idle(1, "midrst_idle");
        step(1, 4'h0, 32'h40, 1, 4'h0, 32'h40, 32'h0, 1, "midrst_rd");

        // Saturation of the write counter
        do_reset("sat_reset");
        for (int k = 0; k < 65537; k++)
            step(0, 4'h0, 32'h0, 1, 4'($urandom_range(1, 15)), rnd_addr(0), $urandom, 0, "sat");
        idle(1, "sat_end");
        chk("sat_count", {16'h0, wr_count}, 32'h0000_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
